// File: rtl/ps2_stream_device.sv
// ps2_stream_device: bus-mapped PS/2 peripheral that packs received bytes into
// fixed-length packets held in a small packet FIFO. It also runs a handshaked
// host-command path that captures the device's single response byte.
module ps2_stream_device #(
    parameter int ADDR_W       = 4,
    parameter int MAX_PKT      = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_CHECK   = 1,
    parameter int RESP_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              enable,
    input  logic              mode,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [7:0]        ps2_cmd,
    output logic              ps2_send,
    input  logic              ps2_cmd_sent,
    input  logic              ps2_timeout,
    input  logic [7:0]        ps2_rx_data,
    input  logic              ps2_rx_valid,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [2:0] MAX_LEN = 3'(MAX_PKT);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RESP} cmd_state_t;

    cmd_state_t        state, state_next;
    logic [TMR_W-1:0]  timer;
    logic [31:0]       addr_ext;
    logic              wr_en, rd_en;
    logic              wr_ctrl, wr_cmd, wr_status, wr_pop, rd_resp, flush;
    logic [2:0]        len;
    logic [2:0]        idx;
    logic [7:0]        asm_buf [8];
    logic [7:0]        fifo_mem [FIFO_DEPTH][8];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [7:0]        seq;
    logic [7:0]        resp_byte;
    logic              resp_valid, cmd_timeout, overflow;
    logic              cmd_start, resp_capture, timeout_set;
    logic              asm_active, rx_take, sync_drop, pkt_done;
    logic              fifo_full, pop_ok, push_ok, overflow_set;
    logic [7:0]        read_next, read_reg;

    assign addr_ext  = 32'(address);
    assign wr_en     = enable && !mode;
    assign rd_en     = enable && mode;
    assign wr_ctrl   = wr_en && (addr_ext == 32'd0);
    assign wr_cmd    = wr_en && (addr_ext == 32'd1);
    assign wr_status = wr_en && (addr_ext == 32'd2);
    assign wr_pop    = wr_en && (addr_ext == 32'd6);
    assign rd_resp   = rd_en && (addr_ext == 32'd3);
    assign flush     = wr_ctrl && data_in[7];

    // Packet assembly is paused while the command path waits for its response byte.
    assign asm_active   = (len != 3'd0) && (state != ST_RESP);
    assign rx_take      = asm_active && ps2_rx_valid;
    assign sync_drop    = (SYNC_CHECK != 0) && (idx == 3'd0) && !ps2_rx_data[3];
    assign pkt_done     = rx_take && !sync_drop && ((idx + 3'd1) == len);
    assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop_ok       = wr_pop && (count != '0);
    assign push_ok      = pkt_done && !flush && (!fifo_full || pop_ok);
    assign overflow_set = pkt_done && !flush && fifo_full && !pop_ok;

    assign ps2_send = (state == ST_SEND);
    assign irq      = (count != '0) || resp_valid;
    assign data_out = rd_en ? read_reg : 8'bz;

    // Command FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Command FSM transitions and the one-cycle event strobes they produce.
    always_comb begin
        state_next   = state;
        cmd_start    = 1'b0;
        resp_capture = 1'b0;
        timeout_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_cmd) begin
                    cmd_start  = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ps2_cmd_sent) begin
                    state_next = ST_RESP;
                end else if (ps2_timeout) begin
                    timeout_set = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (ps2_rx_valid) begin
                    resp_capture = 1'b1;
                    state_next   = ST_IDLE;
                end else if (timer == TMR_W'(RESP_TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Response wait timer counts only while waiting for the response byte.
    always_ff @(posedge clk) begin
        if (reset || state != ST_RESP) timer <= '0;
        else                           timer <= timer + 1'b1;
    end

    // Command byte, response byte and response-valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_cmd    <= 8'h00;
            resp_byte  <= 8'h00;
            resp_valid <= 1'b0;
        end else begin
            if (cmd_start) ps2_cmd <= data_in;
            if (resp_capture) begin
                resp_byte  <= ps2_rx_data;
                resp_valid <= 1'b1;
            end else if (rd_resp) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Sticky status bits; a new event outranks a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_timeout <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (timeout_set)                    cmd_timeout <= 1'b1;
            else if (wr_status && data_in[1])   cmd_timeout <= 1'b0;
            if (overflow_set)                   overflow <= 1'b1;
            else if (wr_status && data_in[2])   overflow <= 1'b0;
        end
    end

    // Packet length, clamped to the largest packet the buffers can hold.
    always_ff @(posedge clk) begin
        if (reset)        len <= 3'd0;
        else if (wr_ctrl) len <= (data_in[2:0] > MAX_LEN) ? MAX_LEN : data_in[2:0];
    end

    // Assembly index; any CTRL write (including flush) restarts the packet.
    always_ff @(posedge clk) begin
        if (reset || wr_ctrl) begin
            idx <= 3'd0;
        end else if (rx_take && !sync_drop) begin
            if (pkt_done) idx <= 3'd0;
            else          idx <= idx + 3'd1;
        end
    end

    // Partial packet bytes collected ahead of the final byte.
    always_ff @(posedge clk) begin
        if (rx_take && !sync_drop && !pkt_done) asm_buf[idx] <= ps2_rx_data;
    end

    // Commit writes the whole packet, the final byte straight from the bus, unused slots zeroed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) < idx)       fifo_mem[wr_ptr][i] <= asm_buf[i];
                else if (3'(i) == idx) fifo_mem[wr_ptr][i] <= ps2_rx_data;
                else                   fifo_mem[wr_ptr][i] <= 8'h00;
            end
        end
    end

    // FIFO pointers and occupancy; flush empties the FIFO and wins over a commit.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    // Sequence number of packets that actually entered the FIFO.
    always_ff @(posedge clk) begin
        if (reset)        seq <= 8'h00;
        else if (push_ok) seq <= seq + 8'h01;
    end

    // Register read decode from the current state.
    always_comb begin
        read_next = 8'h00;
        case (addr_ext)
            32'd0: read_next = {5'b0, len};
            32'd1: read_next = ps2_cmd;
            32'd2: read_next = {3'b0, resp_valid, (count == '0), overflow, cmd_timeout,
                                (state != ST_IDLE)};
            32'd3: read_next = resp_byte;
            32'd4: read_next = 8'(count);
            32'd5: read_next = seq;
            default: begin
                if (addr_ext >= 32'd8 && addr_ext < 32'(8 + MAX_PKT) &&
                    addr_ext[2:0] < len && count != '0)
                    read_next = fifo_mem[rd_ptr][addr_ext[2:0]];
            end
        endcase
    end

    // Registered read data, captured on each edge of an active read.
    always_ff @(posedge clk) begin
        if (reset)      read_reg <= 8'h00;
        else if (rd_en) read_reg <= read_next;
    end

endmodule

// File: tb/tb_ps2_stream_device.sv
// tb_ps2_stream_device: directed vector table, hand-written multi-cycle corner
// sequences, and a randomized run against a queue-based packet model.
module tb_ps2_stream_device;

    localparam int RT    = 40;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] address;
    logic       enable, mode;
    logic [7:0] data_in;
    wire  [7:0] data_out;
    wire  [7:0] ps2_cmd;
    wire        ps2_send;
    logic       ps2_cmd_sent, ps2_timeout;
    logic [7:0] ps2_rx_data;
    logic       ps2_rx_valid;
    wire        irq;

    int checks = 0;
    int errors = 0;

    ps2_stream_device #(
        .ADDR_W(4), .MAX_PKT(4), .FIFO_DEPTH(DEPTH), .SYNC_CHECK(1), .RESP_TIMEOUT(RT)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .enable(enable), .mode(mode),
        .data_in(data_in), .data_out(data_out), .ps2_cmd(ps2_cmd), .ps2_send(ps2_send),
        .ps2_cmd_sent(ps2_cmd_sent), .ps2_timeout(ps2_timeout),
        .ps2_rx_data(ps2_rx_data), .ps2_rx_valid(ps2_rx_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef enum {OP_WR, OP_RD, OP_RX, OP_IRQ, OP_RST} op_t;
    typedef struct {
        op_t        op;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: whole packets as packed words, partial packet as a byte queue.
    int          m_len;
    logic [31:0] m_fifo[$];
    logic [7:0]  m_part[$];
    int          m_seq;
    bit          m_ovf;

    function automatic void add_vec(op_t op, logic [3:0] a, logic [7:0] d, logic [7:0] e, string n);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%02h expected=0x%02h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; enable = 1'b1; mode = 1'b0;
        tick();
        enable = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        address = a; enable = 1'b1; mode = 1'b1;
        tick();
        d = data_out;
        enable = 1'b0; mode = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        ps2_rx_data = b; ps2_rx_valid = 1'b1;
        tick();
        ps2_rx_valid = 1'b0;
    endtask

    // Bus write and received byte landing on the same clock edge.
    task automatic write_with_rx(input logic [3:0] a, input logic [7:0] d, input logic [7:0] b);
        address = a; data_in = d; enable = 1'b1; mode = 1'b0;
        ps2_rx_data = b; ps2_rx_valid = 1'b1;
        tick();
        enable = 1'b0; ps2_rx_valid = 1'b0;
    endtask

    task automatic pulse_sent();
        ps2_cmd_sent = 1'b1;
        tick();
        ps2_cmd_sent = 1'b0;
    endtask

    task automatic pulse_timeout();
        ps2_timeout = 1'b1;
        tick();
        ps2_timeout = 1'b0;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [7:0] e, input string n);
        logic [7:0] got;
        bus_read(a, got);
        checkOutput(n, got, e);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0] got;
        case (v.op)
            OP_WR:  bus_write(v.addr, v.data);
            OP_RX:  rx_byte(v.data);
            OP_RST: do_reset();
            OP_IRQ: checkOutput(v.name, {7'b0, irq}, v.exp);
            OP_RD: begin
                bus_read(v.addr, got);
                checkOutput(v.name, got, v.exp);
            end
            default: ;
        endcase
    endtask

    function automatic void model_ctrl(input logic [7:0] d);
        int l;
        l = int'(d[2:0]);
        m_len = (l > 4) ? 4 : l;
        m_part.delete();
        if (d[7]) m_fifo.delete();
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        logic [31:0] p;
        if (m_len == 0) return;
        if (m_part.size() == 0 && b[3] == 1'b0) return;
        m_part.push_back(b);
        if (m_part.size() == m_len) begin
            if (m_fifo.size() < DEPTH) begin
                p = '0;
                foreach (m_part[i]) p[8*i +: 8] = m_part[i];
                m_fifo.push_back(p);
                m_seq = (m_seq + 1) % 256;
            end else begin
                m_ovf = 1'b1;
            end
            m_part.delete();
        end
    endfunction

    function automatic logic [7:0] model_read(input int a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            0: r = 8'(m_len);
            2: r = {4'b0, (m_fifo.size() == 0), m_ovf, 2'b0};
            4: r = 8'(m_fifo.size());
            5: r = 8'(m_seq);
            8, 9, 10, 11: if (m_fifo.size() != 0 && (a - 8) < m_len) r = m_fifo[0][8*(a-8) +: 8];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    initial begin
        logic [7:0] b;
        int         a;
        int         sel;
        reset = 1'b1; address = '0; enable = 1'b0; mode = 1'b0; data_in = '0;
        ps2_cmd_sent = 1'b0; ps2_timeout = 1'b0; ps2_rx_data = '0; ps2_rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("reset_send", {7'b0, ps2_send}, 8'h00);
        checkOutput("reset_cmd_port", ps2_cmd, 8'h00);

        // Reset state.
        add_vec(OP_IRQ, 4'd0,  8'h00, 8'h00, "reset_irq");
        add_vec(OP_RD,  4'd0,  8'h00, 8'h00, "reset_ctrl");
        add_vec(OP_RD,  4'd1,  8'h00, 8'h00, "reset_cmd");
        add_vec(OP_RD,  4'd2,  8'h00, 8'h08, "reset_status");
        add_vec(OP_RD,  4'd3,  8'h00, 8'h00, "reset_resp");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h00, "reset_count");
        add_vec(OP_RD,  4'd5,  8'h00, 8'h00, "reset_seq");
        add_vec(OP_RD,  4'd8,  8'h00, 8'h00, "reset_head");
        // Mouse stream.
        add_vec(OP_WR,  4'd0,  8'h03, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h08, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h05, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'hFB, 8'h00, "");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h01, "mouse_count");
        add_vec(OP_RD,  4'd5,  8'h00, 8'h01, "mouse_seq");
        add_vec(OP_RD,  4'd8,  8'h00, 8'h08, "mouse_b0");
        add_vec(OP_RD,  4'd9,  8'h00, 8'h05, "mouse_b1");
        add_vec(OP_RD,  4'd10, 8'h00, 8'hFB, "mouse_b2");
        add_vec(OP_RD,  4'd11, 8'h00, 8'h00, "mouse_b3_beyond_len");
        add_vec(OP_RD,  4'd2,  8'h00, 8'h00, "mouse_status");
        add_vec(OP_IRQ, 4'd0,  8'h00, 8'h01, "mouse_irq");
        add_vec(OP_WR,  4'd6,  8'h00, 8'h00, "");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h00, "pop_count");
        add_vec(OP_IRQ, 4'd0,  8'h00, 8'h00, "pop_irq");
        add_vec(OP_RD,  4'd7,  8'h00, 8'h00, "unmapped_read");
        // Sync drop.
        add_vec(OP_RX,  4'd0,  8'h00, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h08, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h01, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h02, 8'h00, "");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h01, "sync_count");
        add_vec(OP_RD,  4'd8,  8'h00, 8'h08, "sync_b0");
        add_vec(OP_RD,  4'd9,  8'h00, 8'h01, "sync_b1");
        add_vec(OP_RD,  4'd10, 8'h00, 8'h02, "sync_b2");
        add_vec(OP_RD,  4'd5,  8'h00, 8'h02, "sync_seq");
        // Overflow.
        add_vec(OP_RST, 4'd0,  8'h00, 8'h00, "");
        add_vec(OP_WR,  4'd0,  8'h01, 8'h00, "");
        for (int i = 0; i < 5; i++) add_vec(OP_RX, 4'd0, 8'(8 + i), 8'h00, "");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h04, "ovf_count");
        add_vec(OP_RD,  4'd2,  8'h00, 8'h04, "ovf_status");
        add_vec(OP_RD,  4'd5,  8'h00, 8'h04, "ovf_seq");
        add_vec(OP_RD,  4'd8,  8'h00, 8'h08, "ovf_head");
        add_vec(OP_RD,  4'd9,  8'h00, 8'h00, "ovf_b1_beyond_len");
        add_vec(OP_WR,  4'd2,  8'h04, 8'h00, "");
        add_vec(OP_RD,  4'd2,  8'h00, 8'h00, "ovf_w1c");
        add_vec(OP_WR,  4'd6,  8'h00, 8'h00, "");
        add_vec(OP_RD,  4'd8,  8'h00, 8'h09, "ovf_order_head");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h03, "ovf_order_count");
        // Flush plus clamped length: LEN 7 behaves as 4-byte packets.
        add_vec(OP_WR,  4'd0,  8'h87, 8'h00, "");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h00, "flush_count");
        add_vec(OP_RX,  4'd0,  8'h08, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h01, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h02, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h03, 8'h00, "");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h01, "clamp_count");
        add_vec(OP_RD,  4'd11, 8'h00, 8'h03, "clamp_b3");
        // LEN 0 disables capture.
        add_vec(OP_WR,  4'd0,  8'h80, 8'h00, "");
        add_vec(OP_RX,  4'd0,  8'h08, 8'h00, "");
        add_vec(OP_RD,  4'd4,  8'h00, 8'h00, "len0_count");

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Command with response; the response byte must not reach assembly.
        do_reset();
        bus_write(4'd0, 8'h03);
        bus_write(4'd1, 8'hF4);
        checkOutput("cmd_send_rise", {7'b0, ps2_send}, 8'h01);
        checkOutput("cmd_port", ps2_cmd, 8'hF4);
        read_check(4'd2, 8'h09, "cmd_busy_status");
        checkOutput("cmd_send_held", {7'b0, ps2_send}, 8'h01);
        pulse_sent();
        checkOutput("cmd_send_fall", {7'b0, ps2_send}, 8'h00);
        rx_byte(8'hFA);
        read_check(4'd2, 8'h18, "resp_status");
        read_check(4'd4, 8'h00, "resp_no_packet");
        checkOutput("resp_irq", {7'b0, irq}, 8'h01);
        read_check(4'd3, 8'hFA, "resp_byte");
        read_check(4'd2, 8'h08, "resp_cleared");
        checkOutput("resp_irq_clear", {7'b0, irq}, 8'h00);
        read_check(4'd1, 8'hF4, "cmd_readback");
        rx_byte(8'h08); rx_byte(8'h01); rx_byte(8'h02);
        read_check(4'd4, 8'h01, "post_resp_count");
        read_check(4'd8, 8'h08, "post_resp_head");
        bus_write(4'd6, 8'h00);

        // Transmit timeout during SEND.
        bus_write(4'd1, 8'hFF);
        pulse_timeout();
        checkOutput("tx_timeout_send", {7'b0, ps2_send}, 8'h00);
        read_check(4'd2, 8'h0A, "tx_timeout_status");
        bus_write(4'd2, 8'h02);
        read_check(4'd2, 8'h08, "tx_timeout_w1c");

        // Response timeout; a CMD write while busy is ignored.
        bus_write(4'd1, 8'hED);
        pulse_sent();
        bus_write(4'd1, 8'h11);
        repeat (RT - 6) tick();
        read_check(4'd2, 8'h09, "resp_wait_busy");
        repeat (10) tick();
        read_check(4'd2, 8'h0A, "resp_timeout_status");
        read_check(4'd1, 8'hED, "busy_cmd_ignored");

        // POP and commit together while full; then flush with commit; then set vs clear.
        do_reset();
        bus_write(4'd0, 8'h01);
        rx_byte(8'h08); rx_byte(8'h09); rx_byte(8'h0A); rx_byte(8'h0B);
        write_with_rx(4'd6, 8'h00, 8'h0C);
        read_check(4'd4, 8'h04, "popcommit_count");
        read_check(4'd2, 8'h00, "popcommit_no_ovf");
        read_check(4'd8, 8'h09, "popcommit_head");
        read_check(4'd5, 8'h05, "popcommit_seq");
        write_with_rx(4'd0, 8'h81, 8'h0D);
        read_check(4'd4, 8'h00, "flushcommit_count");
        read_check(4'd2, 8'h08, "flushcommit_no_ovf");
        rx_byte(8'h08); rx_byte(8'h09); rx_byte(8'h0A); rx_byte(8'h0B);
        write_with_rx(4'd2, 8'h04, 8'h0C);
        read_check(4'd2, 8'h04, "set_beats_clear");
        bus_write(4'd2, 8'h04);
        read_check(4'd2, 8'h00, "clear_alone");

        // Reset mid-packet and mid-command.
        do_reset();
        bus_write(4'd0, 8'h03);
        rx_byte(8'h08); rx_byte(8'h01);
        bus_write(4'd1, 8'hF4);
        do_reset();
        checkOutput("reset_mid_send", {7'b0, ps2_send}, 8'h00);
        read_check(4'd4, 8'h00, "reset_mid_count");
        read_check(4'd5, 8'h00, "reset_mid_seq");
        bus_write(4'd0, 8'h03);
        rx_byte(8'h08); rx_byte(8'h22); rx_byte(8'h33);
        read_check(4'd4, 8'h01, "fresh_count");
        read_check(4'd9, 8'h22, "fresh_b1");
        read_check(4'd10, 8'h33, "fresh_b2");

        // Randomized traffic against the packet model.
        do_reset();
        m_fifo.delete(); m_part.delete(); m_seq = 0; m_ovf = 1'b0; m_len = 0;
        bus_write(4'd0, 8'h84);
        model_ctrl(8'h84);
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(99));
            if (sel < 50) begin
                b = 8'($urandom);
                b[3] = ($urandom_range(3) != 0);
                rx_byte(b);
                model_rx(b);
            end else if (sel < 63) begin
                bus_write(4'd6, 8'($urandom));
                if (m_fifo.size() != 0) void'(m_fifo.pop_front());
            end else if (sel < 68) begin
                bus_write(4'd2, 8'h04);
                m_ovf = 1'b0;
            end else if (sel < 71) begin
                b = 8'h80 | 8'($urandom_range(4));
                bus_write(4'd0, b);
                model_ctrl(b);
            end else begin
                case ($urandom_range(7))
                    0: a = 0;  1: a = 2;  2: a = 4;  3: a = 5;
                    4: a = 8;  5: a = 9;  6: a = 10; default: a = 11;
                endcase
                read_check(4'(a), model_read(a), $sformatf("rand_rd_addr%0d", a));
                checkOutput("rand_irq", {7'b0, irq}, {7'b0, (m_fifo.size() != 0)});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
